// File: rtl/pc_unit.sv
// pc_unit -- fetch-side program counter for the pipelined MIPS core.
//
// Owns the F-stage PC register and picks the next fetch address from
// reset, exception entry, eret, stall hold and D-stage redirects
// (jr > j/jal > taken branch). Redirects land after the delay slot has
// already been fetched (pc == d_pc+4 when D resolves), so nothing is
// squashed here.
//
// Optional build macro: PC_UNIT_RAS_EN -- adds a circular return-address
// stack. jal pushes its link address; jr pops and flags a mispredict.
//
// Ports:
//   clk_i, reset_i          clock (rising edge), synchronous active-high reset
//   stall_i                 hold PC
//   exc_req_i               redirect to HANDLER_PC
//   eret_i, epc_i           redirect to epc_i
//   d_pc_i                  PC of the instruction in D
//   d_imm16_i, d_imm26_i    branch offset / jump index
//   d_branch_i, d_br_taken_i, d_jump_i, d_jal_i, d_jr_i   D-stage control
//   d_rs_i                  forwarded rs (jr target)
//   pc_o                    current fetch PC
//   link_pc_o               d_pc+8 (jal write-back)
//   f_adel_o                fetch address fault (misaligned / out of text)
//   redirect_o              D-stage redirect accepted this cycle
//   ras_miss_o              registered pulse: jr target mispredicted
module pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI    = 32'h0000_6ffc,
  parameter int          RAS_DEPTH  = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        stall_i,
  input  logic        exc_req_i,
  input  logic        eret_i,
  input  logic [31:0] epc_i,
  input  logic [31:0] d_pc_i,
  input  logic [15:0] d_imm16_i,
  input  logic [25:0] d_imm26_i,
  input  logic        d_branch_i,
  input  logic        d_br_taken_i,
  input  logic        d_jump_i,
  input  logic        d_jal_i,
  input  logic        d_jr_i,
  input  logic [31:0] d_rs_i,
  output logic [31:0] pc_o,
  output logic [31:0] link_pc_o,
  output logic        f_adel_o,
  output logic        redirect_o,
  output logic        ras_miss_o
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] d_pc4, br_tgt, j_tgt;
  logic        br_take;

  assign d_pc4   = d_pc_i + 32'd4;
  assign br_tgt  = d_pc4 + {{14{d_imm16_i[15]}}, d_imm16_i, 2'b00};
  assign j_tgt   = {d_pc4[31:28], d_imm26_i, 2'b00};
  assign br_take = d_branch_i & d_br_taken_i;

  assign link_pc_o  = d_pc_i + 32'd8;
  assign redirect_o = ~reset_i & ~exc_req_i & ~eret_i & ~stall_i &
                      (d_jr_i | d_jump_i | br_take);

  // Next PC for the unstalled, non-exception case.
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (d_jr_i)        pc_d = d_rs_i;
    else if (d_jump_i) pc_d = j_tgt;
    else if (br_take)  pc_d = br_tgt;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)        pc_q <= RESET_PC;
    else if (exc_req_i) pc_q <= HANDLER_PC;
    else if (eret_i)    pc_q <= epc_i;
    else if (!stall_i)  pc_q <= pc_d;
  end

  assign pc_o     = pc_q;
  // Fault only reports; the PC keeps advancing and the exception path
  // elsewhere decides what to do with it.
  assign f_adel_o = (pc_q[1:0] != 2'b00) | (pc_q < TEXT_LO) | (pc_q > TEXT_HI);

`ifdef PC_UNIT_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   ras_q [RAS_DEPTH];
  logic [PW-1:0] wp_q;      // next write slot; top entry sits at wp_q-1
  logic [CW-1:0] cnt_q;
  logic          ras_miss_q;
  logic [PW-1:0] top_idx;
  logic          do_pop, do_push;

  assign top_idx = wp_q - PW'(1);
  assign do_pop  = redirect_o & d_jr_i;
  // jr outranks jump, so a (illegal) jr+jal cycle only pops.
  assign do_push = redirect_o & d_jal_i & ~d_jr_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wp_q       <= '0;
      cnt_q      <= '0;
      ras_miss_q <= 1'b0;
    end else begin
      ras_miss_q <= do_pop & ((cnt_q == '0) | (ras_q[top_idx] != d_rs_i));
      if (do_push) begin
        // Full stack wraps and overwrites the oldest entry.
        ras_q[wp_q] <= link_pc_o;
        wp_q        <= wp_q + PW'(1);
        if (cnt_q != CW'(RAS_DEPTH)) cnt_q <= cnt_q + CW'(1);
      end else if (do_pop && cnt_q != '0) begin
        wp_q  <= top_idx;
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  assign ras_miss_o = ras_miss_q;
`else
  assign ras_miss_o = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;
  logic        clk = 1'b0;
  logic        reset, stall, exc_req, eret;
  logic [31:0] epc, d_pc, d_rs;
  logic [15:0] d_imm16;
  logic [25:0] d_imm26;
  logic        d_branch, d_br_taken, d_jump, d_jal, d_jr;
  logic [31:0] pc, link_pc;
  logic        f_adel, redirect, ras_miss;

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk_i(clk), .reset_i(reset), .stall_i(stall), .exc_req_i(exc_req),
    .eret_i(eret), .epc_i(epc), .d_pc_i(d_pc), .d_imm16_i(d_imm16),
    .d_imm26_i(d_imm26), .d_branch_i(d_branch), .d_br_taken_i(d_br_taken),
    .d_jump_i(d_jump), .d_jal_i(d_jal), .d_jr_i(d_jr), .d_rs_i(d_rs),
    .pc_o(pc), .link_pc_o(link_pc), .f_adel_o(f_adel),
    .redirect_o(redirect), .ras_miss_o(ras_miss)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; exc_req = 0; eret = 0; epc = '0; d_pc = '0; d_rs = '0;
    d_imm16 = '0; d_imm26 = '0; d_branch = 0; d_br_taken = 0;
    d_jump = 0; d_jal = 0; d_jr = 0;
  endtask

  task automatic jr_to(input logic [31:0] tgt);
    idle(); d_jr = 1; d_rs = tgt;
    #1 chk("jr_redirect", 32'(redirect), 32'd1);
    tick();
    idle();
  endtask

  initial begin
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
    #1;
    chk("rst_pc", pc, 32'h3000);
    chk("rst_adel", 32'(f_adel), 32'd0);
    chk("rst_redir", 32'(redirect), 32'd0);
    chk("rst_rasmiss", 32'(ras_miss), 32'd0);
    tick(); chk("free1", pc, 32'h3004);
    tick(); chk("free2", pc, 32'h3008);
    tick(); chk("free3", pc, 32'h300c);

    // taken branch back: 0x3008+4-8
    d_pc = 32'h3008; d_branch = 1; d_br_taken = 1; d_imm16 = 16'hfffe;
    #1 chk("br_redir", 32'(redirect), 32'd1);
    tick(); chk("br_taken_pc", pc, 32'h3004);
    idle();
    tick(); tick(); chk("free4", pc, 32'h300c);
    d_pc = 32'h3008; d_branch = 1; d_br_taken = 0; d_imm16 = 16'hfffe;
    #1 chk("br_nt_redir", 32'(redirect), 32'd0);
    tick(); chk("br_nt_pc", pc, 32'h3010);

    // jal, first stalled then released
    idle();
    d_pc = 32'h3010; d_jump = 1; d_jal = 1; d_imm26 = 26'h0c40; stall = 1;
    #1 chk("jal_stall_redir", 32'(redirect), 32'd0);
    chk("link_pc", link_pc, 32'h3018);
    tick(); chk("stall_hold", pc, 32'h3010);
    stall = 0;
    #1 chk("jal_redir", 32'(redirect), 32'd1);
    tick(); chk("jal_pc", pc, 32'h3100);

    // exception beats jr and stall; eret beats stall
    idle();
    exc_req = 1; d_jr = 1; d_rs = 32'h5000; stall = 1;
    #1 chk("exc_redir", 32'(redirect), 32'd0);
    tick(); chk("exc_pc", pc, 32'h4180);
    idle();
    eret = 1; epc = 32'h3020; stall = 1;
    tick(); chk("eret_pc", pc, 32'h3020);
    idle();

    // fetch fault boundaries; pc keeps advancing while faulting
    jr_to(32'h3002); chk("jr_mis_pc", pc, 32'h3002); chk("adel_mis", 32'(f_adel), 32'd1);
    tick(); chk("adel_adv_pc", pc, 32'h3006);
    jr_to(32'h7000); chk("adel_hi", 32'(f_adel), 32'd1);
    jr_to(32'h6ffc); chk("adel_top_ok", 32'(f_adel), 32'd0);
    jr_to(32'h2ffc); chk("adel_lo", 32'(f_adel), 32'd1);
    jr_to(32'h3000); chk("adel_bot_ok", 32'(f_adel), 32'd0);
`ifndef PC_UNIT_RAS_EN
    chk("no_ras_miss", 32'(ras_miss), 32'd0);
`endif

    // 32-bit wrap on branch target
    d_pc = 32'hfffffff8; d_branch = 1; d_br_taken = 1; d_imm16 = 16'h0002;
    tick(); chk("br_wrap_pc", pc, 32'h4);
    idle();

    // reset dominates a pending redirect and stall
    reset = 1; d_jr = 1; d_rs = 32'h5000; stall = 1;
    #1 chk("rst_redir_blk", 32'(redirect), 32'd0);
    tick(); chk("rst_mid_pc", pc, 32'h3000);
    reset = 0; idle();

`ifdef PC_UNIT_RAS_EN
    begin
      logic [31:0] lnk [5];
      logic [31:0] exp_miss [5];
      exp_miss[0] = 0; exp_miss[1] = 0; exp_miss[2] = 0; exp_miss[3] = 0; exp_miss[4] = 1;
      for (int i = 0; i < 5; i++) begin
        lnk[i] = 32'h3100 + 32'(i) * 32'h10 + 32'd8;
        idle();
        d_pc = 32'h3100 + 32'(i) * 32'h10; d_jump = 1; d_jal = 1; d_imm26 = 26'h0c40;
        tick();
      end
      for (int i = 4; i >= 0; i--) begin
        jr_to(lnk[i]);
        chk("ras_pop", 32'(ras_miss), exp_miss[4-i]);
      end
      tick(); chk("ras_pulse_end", 32'(ras_miss), 32'd0);
      jr_to(lnk[0]);
      chk("ras_empty", 32'(ras_miss), 32'd1);
    end
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Fetch-side program counter for the pipelined MIPS core: owns the F-stage PC register and computes next PC.
- Resolves branch, j/jal and jr redirects issued from D, with delay-slot semantics.
- Adds exception/eret redirection, stall hold, and fetch-address fault detection.
- Optional return-address stack checks jr targets against the predicted return address.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- HANDLER_PC, 32'h0000_4180, exception entry vector.
- TEXT_LO, 32'h0000_3000, lowest legal fetch address.
- TEXT_HI, 32'h0000_6ffc, highest legal fetch address.
- RAS_DEPTH, 4, return-address-stack entries (≥2, power of two); used only with RAS_EN.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hold PC (hazard unit)
- exc_req  in  1  take exception this cycle
- eret  in  1  return from exception
- epc  in  32  eret target
- d_pc  in  32  PC of instruction in D
- d_imm16  in  16  branch offset
- d_imm26  in  26  jump index
- d_branch  in  1  D holds conditional branch
- d_br_taken  in  1  branch condition true (compared in D)
- d_jump  in  1  D holds j or jal
- d_jal  in  1  D holds jal (subset of d_jump)
- d_jr  in  1  D holds jr
- d_rs  in  32  forwarded rs value (jr target)
- pc  out  32  current fetch PC
- link_pc  out  32  d_pc+8, for jal write-back
- f_adel  out  1  fetch address fault
- redirect  out  1  D-stage redirect accepted this cycle (comb)
- ras_miss  out  1  registered one-cycle pulse: jr target mispredicted

Behaviour:
- All arithmetic is 32-bit modulo 2^32; no carry out.
- Branch target: d_pc+4+{sext(d_imm16),2'b00}.
- Jump target: {(d_pc+4)[31:28], d_imm26, 2'b00}.
- jr target: d_rs.
- Update at posedge clk, first matching rule wins:
  1. reset → pc=RESET_PC, ras_miss=0, RAS emptied.
  2. exc_req → pc=HANDLER_PC.
  3. eret → pc=epc.
  4. stall → pc held.
  5. d_jr → jr target.
  6. d_jump → jump target.
  7. d_branch & d_br_taken → branch target.
  8. otherwise pc+4 (untaken branch falls through into delay slot successor).
- redirect = ~reset & ~exc_req & ~eret & ~stall & (d_jr | d_jump | (d_branch & d_br_taken)).
- Delay slot: the redirect is applied while pc already equals d_pc+4. The slot instruction is never squashed by this block.
- Simultaneous D flags are illegal; the priority above resolves them deterministically (jr > jump > branch).
- exc_req with stall: the exception wins and stall is ignored. The same holds for eret.
- link_pc is combinational from d_pc. No latency.
- f_adel is combinational from the pc register: pc[1:0]≠0 or pc<TEXT_LO or pc>TEXT_HI (unsigned).
  - The PC still advances normally while f_adel is high; exception handling is outside this block.
- Reset mid-stall or mid-redirect: reset dominates, and the next pc is RESET_PC.
- Without RAS_EN, ras_miss is held at 0.

Optional Feature:
- Macro: PC_UNIT_RAS_EN.
- With the macro defined: circular stack of RAS_DEPTH 32-bit entries plus a count 0..RAS_DEPTH.
- Stack updates happen only on cycles where redirect=1.
- Push (d_jal): write link_pc at top; count saturates at RAS_DEPTH.
  - Push when full overwrites the oldest entry.
- Pop (d_jr):
  - Compare d_rs with the top entry.
  - ras_miss is 1 next cycle if count==0 or top≠d_rs, else 0.
  - On count>0, pop (count−1).
  - Pop when empty leaves count at 0.
- Stall, exc_req and eret leave the stack untouched.
- ras_miss is a one-cycle pulse; it is 0 on cycles with no jr pop.
- Without the macro: no stack storage, ras_miss tied 0, all other behaviour identical.

Test Plan:
- Reset, then 3 free-running cycles → pc sequence 0x3000, 0x3004, 0x3008, 0x300c; f_adel=0; redirect=0.
- d_pc=0x3008, d_branch=1, d_br_taken=1, d_imm16=16'hfffe, while pc=0x300c → next pc=0x3004, redirect=1. Same inputs with d_br_taken=0 → next pc=0x3010.
- d_pc=0x3010, d_jal=d_jump=1, d_imm26=0x0c40 → pc=0x00003100, link_pc=0x3018. Same inputs with stall=1 → pc held, redirect=0.
- exc_req=1 together with d_jr=1 and stall=1 → pc=0x4180. Then eret=1, epc=0x3020 → pc=0x3020.
- d_jr with d_rs=0x3002 → pc=0x3002, f_adel=1. d_rs=0x7000 → f_adel=1.
- With PC_UNIT_RAS_EN and RAS_DEPTH=4:
  - 5 jal pushes (links L1..L5), then 5 jr using d_rs=L5..L1 → ras_miss pulses 0,0,0,0,1 (L1 was overwritten).
  - Then jr on the empty stack → ras_miss=1.
